// File: rtl/seg_scan_mux.sv
// Scan controller for an 8-digit hex seven-segment display: holds a display word and dp mask,
// steps through the digits at a prescaled rate and emits one nibble/select/dp per digit slot.
module seg_scan_mux #(
   parameter int DIV_BITS = 18,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   output logic [3:0]  digit_nib,
   output logic [7:0]  an_sel,
   output logic        dp_out,
   output logic        frame_done
);

   logic [DIV_BITS-1:0] pre;
   logic [2:0]          idx;
   logic [31:0]         act_word;
   logic [31:0]         pend_word;
   logic [7:0]          act_mask;
   logic [7:0]          pend_mask;
   logic                pend_flag;

   logic                tick;
   logic                boundary;
   logic [3:0]          cur_nib;
   logic                blank;

   always_comb begin
      tick     = en && (pre == '1);
      boundary = tick && (idx == 3'd7);
      cur_nib  = act_word[{idx, 2'b00} +: 4];
      // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
      blank    = BLANK_LZ && (idx != 3'd0) && ((act_word >> {idx, 2'b00}) == 32'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         idx <= 3'd0;
      end else if (en) begin
         pre <= pre + DIV_BITS'(1);
         if (tick) idx <= idx + 3'd1;
      end
   end

   // The active word only changes at a frame boundary, so a frame is never torn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_word  <= 32'd0;
         act_mask  <= 8'd0;
         pend_word <= 32'd0;
         pend_mask <= 8'd0;
         pend_flag <= 1'b0;
      end else begin
         if (load) begin
            pend_word <= value;
            pend_mask <= dp_mask;
         end
         if (boundary) begin
            if (load) begin
               act_word <= value;
               act_mask <= dp_mask;
            end else if (pend_flag) begin
               act_word <= pend_word;
               act_mask <= pend_mask;
            end
            pend_flag <= 1'b0;
         end else if (load) begin
            pend_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_sel     <= 8'h00;
         digit_nib  <= 4'h0;
         dp_out     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         an_sel     <= en ? (8'h01 << idx) : 8'h00;
         digit_nib  <= blank ? 4'hF : cur_nib;
         dp_out     <= act_mask[idx] & en;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: blanking and non-blanking instances driven together and compared
// every cycle against a frame-position reference model.
module tb_seg_scan_mux;

   localparam int DB      = 2;
   localparam int DIG_CYC = 1 << DB;
   localparam int FRAME   = 8 * DIG_CYC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [31:0] value = 32'd0;
   logic [7:0]  dp_mask = 8'd0;

   logic [3:0]  nib_b, nib_f;
   logic [7:0]  an_b, an_f;
   logic        dp_b, dp_f, fd_b, fd_f;

   seg_scan_mux #(.DIV_BITS(DB), .BLANK_LZ(1'b1)) u_blank (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_mask(dp_mask),
      .digit_nib(nib_b), .an_sel(an_b), .dp_out(dp_b), .frame_done(fd_b)
   );

   seg_scan_mux #(.DIV_BITS(DB), .BLANK_LZ(1'b0)) u_full (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_mask(dp_mask),
      .digit_nib(nib_f), .an_sel(an_f), .dp_out(dp_f), .frame_done(fd_f)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: position within the frame counted in enabled cycles.
   int          pos;
   logic [31:0] m_act_word, m_pend_word;
   logic [7:0]  m_act_mask, m_pend_mask;
   bit          m_pend_flag;
   logic [7:0]  exp_an;
   logic [3:0]  exp_nib_b, exp_nib_f;
   logic        exp_dp, exp_fd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos         = 0;
      m_act_word  = 32'd0;
      m_act_mask  = 8'd0;
      m_pend_word = 32'd0;
      m_pend_mask = 8'd0;
      m_pend_flag = 1'b0;
      exp_an      = 8'h00;
      exp_nib_b   = 4'h0;
      exp_nib_f   = 4'h0;
      exp_dp      = 1'b0;
      exp_fd      = 1'b0;
   endtask

   task automatic model_edge(input logic e, input logic l, input logic [31:0] v, input logic [7:0] m);
      int d;
      logic [31:0] upper;
      logic [3:0]  nib;
      bit          boundary;
      d         = pos / DIG_CYC;
      upper     = m_act_word >> (4 * d);
      nib       = upper[3:0];
      exp_an    = e ? 8'(1 << d) : 8'h00;
      exp_nib_f = nib;
      exp_nib_b = (d != 0 && upper == 32'd0) ? 4'hF : nib;
      exp_dp    = e & m_act_mask[d];
      boundary  = e && (pos == FRAME - 1);
      exp_fd    = boundary;
      if (l) begin
         m_pend_word = v;
         m_pend_mask = m;
         m_pend_flag = 1'b1;
      end
      if (boundary && m_pend_flag) begin
         m_act_word  = m_pend_word;
         m_act_mask  = m_pend_mask;
         m_pend_flag = 1'b0;
      end
      if (e) pos = (pos + 1) % FRAME;
   endtask

   task automatic check_outputs(input string ph);
      check({ph, ".an_b"},  32'(an_b),  32'(exp_an));
      check({ph, ".nib_b"}, 32'(nib_b), 32'(exp_nib_b));
      check({ph, ".dp_b"},  32'(dp_b),  32'(exp_dp));
      check({ph, ".fd_b"},  32'(fd_b),  32'(exp_fd));
      check({ph, ".an_f"},  32'(an_f),  32'(exp_an));
      check({ph, ".nib_f"}, 32'(nib_f), 32'(exp_nib_f));
      check({ph, ".dp_f"},  32'(dp_f),  32'(exp_dp));
      check({ph, ".fd_f"},  32'(fd_f),  32'(exp_fd));
   endtask

   task automatic step(input string ph, input logic e, input logic l,
                       input logic [31:0] v, input logic [7:0] m);
      en      = e;
      load    = l;
      value   = v;
      dp_mask = m;
      @(posedge clk);
      model_edge(e, l, v, m);
      #1;
      check_outputs(ph);
   endtask

   task automatic idle(input string ph, input int n);
      for (int i = 0; i < n; i++) step(ph, 1'b1, 1'b0, 32'd0, 8'd0);
   endtask

   initial begin
      model_reset();
      #1;
      check_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset_hold");
      rst_n = 1'b1;

      idle("free_run", 40);

      step("load_12a5", 1'b1, 1'b1, 32'h0000_12A5, 8'h04);
      idle("show_12a5", 70);

      step("load_1s", 1'b1, 1'b1, 32'h1111_1111, 8'h0F);
      idle("between", 3);
      step("load_2s", 1'b1, 1'b1, 32'h2222_2222, 8'hF0);
      idle("show_2s", 70);

      for (int i = 0; i < FRAME && pos != FRAME - 1; i++) step("to_bnd", 1'b1, 1'b0, 32'd0, 8'd0);
      check("reach_boundary", 32'(pos), 32'(FRAME - 1));
      step("load_bnd", 1'b1, 1'b1, 32'h0BAD_F00D, 8'hA5);
      idle("show_bnd", 40);

      idle("pre_gap", 2);
      for (int i = 0; i < 10; i++)
         step("gap", 1'b0, (i == 4), 32'h0000_0C00, 8'h81);
      idle("resume", 40);

      step("pend_before_rst", 1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
      idle("pre_rst", 3);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle("post_rst", 40);

      for (int i = 0; i < 2000; i++) begin
         logic        e, l;
         logic [31:0] v;
         e = ($urandom_range(0, 9) != 0);
         l = ($urandom_range(0, 15) == 0);
         v = 32'($urandom) >> (4 * $urandom_range(0, 8));
         step("random", e, l, v, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
